sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of switch inputs.
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, number of consecutive agreeing samples before a bit changes (minimum 1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw_raw  input  WIDTH  asynchronous raw switch levels.
REQ-006 sw_out  output  WIDTH  debounced switch levels, registered; feeds the downstream selector sw port.
REQ-007 sw_rise  output  WIDTH  one-cycle pulse per bit on a debounced 0->1 change.
REQ-008 sw_fall  output  WIDTH  one-cycle pulse per bit on a debounced 1->0 change.
REQ-009 sw_changed  output  1  one-cycle pulse when any bit of sw_out changes.
REQ-010 sw_stable  output  1  high iff the synchronized sample equals sw_out on every bit.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer; the second flop is the sample s[i].
REQ-012 Each bit SHALL be an independent two-state machine: STABLE (s[i]==sw_out[i], counter held at 0) and COUNTING (s[i]!=sw_out[i]).
REQ-013 In COUNTING with counter < DEB_CYCLES-1, the counter SHALL increment by 1 per clock.
REQ-014 In COUNTING with counter == DEB_CYCLES-1, sw_out[i] SHALL take s[i] on that edge and the counter SHALL return to 0 (STABLE).
REQ-015 If s[i] returns to sw_out[i] before the terminal count, the counter SHALL clear to 0 and sw_out[i] SHALL not change (bounce rejection).
REQ-016 Latency: a raw level held steady SHALL appear on sw_out on the (DEB_CYCLES+2)th rising edge after it is first sampled by the synchronizer.
REQ-017 The counter width SHALL be $clog2(DEB_CYCLES+1); the counter SHALL never wrap.
REQ-018 sw_rise[i]/sw_fall[i] SHALL be registered and asserted on the same edge that sw_out[i] changes, for exactly one cycle.
REQ-019 sw_changed SHALL equal the registered OR of all sw_rise and sw_fall bits, asserted on the same edge.
REQ-020 Bits changing on the same cycle SHALL update and pulse on the same edge, independently.
REQ-021 sw_stable SHALL be combinational from s and sw_out.

Reset
REQ-022 On rst, synchronizer flops, counters, sw_out, sw_rise, sw_fall and sw_changed SHALL all become 0.
REQ-023 rst SHALL override every other event in the same cycle, including a terminal count.
REQ-024 After reset with sw_raw bits high, those bits SHALL debounce normally from 0 and produce sw_rise pulses.

Configuration
REQ-025 Macro SW_DEBOUNCE_EDGE_EN: when defined, sw_rise, sw_fall and sw_changed SHALL behave per REQ-018/019.
REQ-026 When SW_DEBOUNCE_EDGE_EN is undefined, those outputs SHALL be tied to 0, their registers SHALL not exist, and sw_out/sw_stable behaviour SHALL be unchanged.

Structure
REQ-027 Package sw_debounce_pkg SHALL hold SW_WIDTH=10, the DEB_CYCLES default, and the per-bit state enum (STABLE, COUNTING).
REQ-028 Sub-module sw_debounce_bit (synchronizer, counter, state, edge pulses for one bit) SHALL be instantiated WIDTH times via generate.

Verification (DEB_CYCLES=4, WIDTH=10)
REQ-029 rst high with sw_raw=0 -> sw_out=0, sw_rise=sw_fall=0, sw_changed=0, sw_stable=1 (once the synchronizer holds 0).
REQ-030 sw_raw[0] 0->1 held -> sw_out[0]=1 on the 6th edge after first sample; sw_rise[0] and sw_changed high for that one cycle only.
REQ-031 sw_raw[3] high for 3 cycles then low -> sw_out and all pulses stay 0; sw_stable is low during the glitch, then returns to 1.
REQ-032 sw_raw 0->10'h3FF in one cycle -> all sw_out bits rise on the same edge; sw_rise=10'h3FF for one cycle; then 10'h3FF->0 -> sw_fall=10'h3FF.
REQ-033 rst asserted after 2 COUNTING cycles on sw_raw[5] -> sw_out=0, counter=0; sw_out[5] rises a full 6 edges after rst release.
REQ-034 SW_DEBOUNCE_EDGE_EN undefined, repeat REQ-030 stimulus -> sw_out timing identical; sw_rise, sw_fall and sw_changed stay 0 throughout.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared constants and the per-bit debounce state type
// used by sw_debounce and sw_debounce_bit.
package sw_debounce_pkg;

    // Number of board switches feeding the downstream selector.
    localparam int SW_WIDTH = 10;

    // Default number of consecutive agreeing samples before a bit changes.
    localparam int DEB_CYCLES_DEF = 1000000;

    // Per-bit debounce state.
    //   STABLE   : synchronized sample agrees with the debounced level,
    //              counter held at zero.
    //   COUNTING : sample disagrees with the debounced level, counter
    //              runs toward the terminal count.
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_t;

    // Counter width able to hold every value 0 .. cycles without wrapping.
    function automatic int deb_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit -- 2-flop synchronizer, agreement
// counter, STABLE/COUNTING state machine and (optionally) edge pulses.
//
// Build option: define SW_DEBOUNCE_EDGE_EN to create the rise/fall pulse
// registers and the toggle indication. Without it those ports do not exist
// and the debounced level behaves identically.
//
// The state register always equals (sample != level) for the cycle it is
// valid in, so the next state is computed from the value the sample will
// take (sync1) and the level that is about to be registered.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sample,
    output logic level,
    output logic counting
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall,
    output logic toggle
`endif
);

    localparam int CW = deb_cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    deb_state_t    state_q;
    deb_state_t    state_d;

    // Synchronizer, debounced level, counter and state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= STABLE;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next-state logic: count while disagreeing, commit at terminal count,
    // clear on agreement so a bounce restarts the full qualification window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
            end
            COUNTING: begin
                if (cnt_q == TERM) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        state_d = (sync1_q != level_d) ? COUNTING : STABLE;
    end

    assign sample   = sync2_q;
    assign level    = level_q;
    assign counting = (state_q == COUNTING);

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses, registered on the same edge the debounced level moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign rise   = rise_q;
    assign fall   = fall_q;
    assign toggle = level_d ^ level_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: WIDTH independent switch debouncers with debounced levels,
// per-bit edge pulses, a combined change pulse and a stability flag.
//
// Build option: define SW_DEBOUNCE_EDGE_EN to enable sw_rise, sw_fall and
// sw_changed. Without it those outputs are constant 0 and no pulse
// registers are built; sw_out and sw_stable are unaffected.
//
// dbg_counting exposes each bit's state register (1 = COUNTING).
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH      = SW_WIDTH,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             sw_stable,
    output logic [WIDTH-1:0] dbg_counting
);

    logic [WIDTH-1:0] sample;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] toggle;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw      (sw_raw[i]),
            .sample   (sample[i]),
            .level    (sw_out[i]),
            .counting (dbg_counting[i])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i]),
            .toggle   (toggle[i])
`endif
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic changed_q;

    // Any-bit change pulse, aligned with the per-bit rise/fall pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |toggle;
        end
    end

    assign sw_changed = changed_q;
`else
    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = 1'b0;
`endif

    // Stable when every synchronized sample already matches its output.
    assign sw_stable = (sample == sw_out);

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and randomized checks of sw_debounce
// (WIDTH=10, DEB_CYCLES=4) against a sample-window reference model.
module tb_sw_debounce;

    localparam int W   = 10;
    localparam int DEB = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
    logic         sw_stable;
    logic [W-1:0] dbg_counting;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH      (W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_raw       (sw_raw),
        .sw_out       (sw_out),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .sw_changed   (sw_changed),
        .sw_stable    (sw_stable),
        .dbg_counting (dbg_counting)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A bit takes the sample value once the last DEB samples presented to
    // it (since reset or its previous change) all disagree with its level.
    logic [W-1:0] m_sync1, m_s, m_out, m_rise, m_fall, m_nxt;
    logic         m_changed;
    bit           m_valid = 1'b0;
    bit           m_all_diff;
    bit           win [W][$];

    always @(posedge clk) begin
        if (rst) begin
            m_sync1   = '0;
            m_s       = '0;
            m_out     = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_changed = 1'b0;
            for (int i = 0; i < W; i++) win[i].delete();
            m_valid = 1'b1;
        end else begin
            m_nxt = m_out;
            for (int i = 0; i < W; i++) begin
                win[i].push_back(m_s[i]);
                if (win[i].size() > DEB) win[i].delete(0);
                if (win[i].size() == DEB) begin
                    m_all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (win[i][j] == m_out[i]) m_all_diff = 1'b0;
                    if (m_all_diff) begin
                        m_nxt[i] = m_s[i];
                        win[i].delete();
                    end
                end
            end
            m_rise    = m_nxt & ~m_out;
            m_fall    = ~m_nxt & m_out;
            m_changed = |(m_rise | m_fall);
            m_out     = m_nxt;
            m_s       = m_sync1;
            m_sync1   = sw_raw;
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("out", sw_out, m_out);
            check("rise", sw_rise, EDGE_EN ? m_rise : '0);
            check("fall", sw_fall, EDGE_EN ? m_fall : '0);
            check_int("changed", int'(sw_changed), EDGE_EN ? int'(m_changed) : 0);
            check_int("stable", int'(sw_stable), int'(m_s == m_out));
            check("counting", dbg_counting, m_s ^ m_out);
        end
    end

    // ---------------- driver helpers ----------------
    // Count rising edges until sw_out leaves 'from'; -1 if it never does.
    task automatic wait_change(input logic [W-1:0] from, output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (sw_out !== from) begin
                n = k;
                return;
            end
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    int           n;
    bit           seen_unstable;
    logic [W-1:0] any_out;
    logic [W-1:0] any_pulse;
    logic [W-1:0] flip;

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
        repeat (4) @(negedge clk);
        check("reset_out", sw_out, '0);
        check("reset_rise", sw_rise, '0);
        check("reset_fall", sw_fall, '0);
        check_int("reset_changed", int'(sw_changed), 0);
        check_int("reset_stable", int'(sw_stable), 1);

        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single bit rise: 6th edge after first sample
        sw_raw[0] = 1'b1;
        wait_change(sw_out, n);
        check_int("lat_rise0", n, 6);
        check("rise0_out", sw_out, 10'h001);
        check("rise0_pulse", sw_rise, EDGE_EN ? 10'h001 : 10'h000);
        check_int("rise0_changed", int'(sw_changed), EDGE_EN ? 1 : 0);
        @(posedge clk);
        #1;
        check("rise0_gone", sw_rise, '0);
        check_int("rise0_changed_gone", int'(sw_changed), 0);

        @(negedge clk);
        sw_raw[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("fall0_out", sw_out, '0);

        // glitch on bit 3 for 3 cycles: rejected
        sw_raw[3]     = 1'b1;
        seen_unstable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (!sw_stable) seen_unstable = 1'b1;
        end
        @(negedge clk);
        sw_raw[3] = 1'b0;
        any_out   = '0;
        any_pulse = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!sw_stable) seen_unstable = 1'b1;
            any_out   = any_out | sw_out;
            any_pulse = any_pulse | sw_rise | sw_fall | {{(W-1){1'b0}}, sw_changed};
        end
        check_int("glitch_unstable_seen", int'(seen_unstable), 1);
        check("glitch_out", any_out, '0);
        check("glitch_pulses", any_pulse, '0);
        check_int("glitch_stable_after", int'(sw_stable), 1);

        // all bits together
        @(negedge clk);
        sw_raw = '1;
        wait_change(sw_out, n);
        check_int("lat_all_rise", n, 6);
        check("all_rise_out", sw_out, 10'h3FF);
        check("all_rise_pulse", sw_rise, EDGE_EN ? 10'h3FF : 10'h000);
        @(negedge clk);
        sw_raw = '0;
        wait_change(sw_out, n);
        check_int("lat_all_fall", n, 6);
        check("all_fall_out", sw_out, 10'h000);
        check("all_fall_pulse", sw_fall, EDGE_EN ? 10'h3FF : 10'h000);

        // reset in the middle of counting on bit 5
        repeat (3) @(negedge clk);
        sw_raw[5] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out", sw_out, '0);
        check("rst_mid_counting", dbg_counting, '0);
        rst = 1'b0;
        wait_change(sw_out, n);
        check_int("lat_after_rst", n, 6);
        check("after_rst_out", sw_out, 10'h020);
        check("after_rst_pulse", sw_rise, EDGE_EN ? 10'h020 : 10'h000);

        @(negedge clk);
        sw_raw = '0;
        repeat (10) @(negedge clk);

        // randomized bouncing with occasional reset
        repeat (600) begin
            @(negedge clk);
            flip = '0;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 6) == 0) flip[i] = 1'b1;
            sw_raw = sw_raw ^ flip;
            rst    = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
